// File: rtl/radix5_emitter_pkg.sv
// Shared widths, limits and FSM state type for the radix-5 digit emitter.
// No ports; imported by div_64_5 and radix5_digit_emitter.
package radix5_emitter_pkg;

  localparam int DATA_W     = 64;
  localparam int QUOT_W     = 62;  // 2^64 / 5 < 2^62
  localparam int DIGIT_W    = 3;
  localparam int IDX_W      = 5;
  localparam int MAX_DIGITS = 28;  // 5^28 > 2^64

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/div_64_5.sv
// Combinational unsigned divide of a 64-bit value by the constant 5.
// Ports:
//   x         in  64  dividend
//   quotient  out 62  x / 5
//   remainder out 3   x mod 5, always 0..4
module div_64_5
  import radix5_emitter_pkg::*;
(
  input  logic [DATA_W-1:0]  x,
  output logic [QUOT_W-1:0]  quotient,
  output logic [DIGIT_W-1:0] remainder
);

  logic [DIGIT_W-1:0] rem;
  logic [DIGIT_W:0]   trial;

  // Restoring long division, one dividend bit per step. The top two bits
  // form a value of at most 3, so they seed the remainder directly and
  // contribute no quotient bits. The remainder stays below 5, so each
  // trial value fits in 4 bits.
  always_comb begin
    rem      = {1'b0, x[DATA_W-1:DATA_W-2]};
    trial    = '0;
    quotient = '0;
    for (int i = QUOT_W - 1; i >= 0; i--) begin
      trial = {rem, x[i]};
      if (trial >= 4'd5) begin
        quotient[i] = 1'b1;
        rem         = DIGIT_W'(trial - 4'd5);
      end else begin
        quotient[i] = 1'b0;
        rem         = trial[DIGIT_W-1:0];
      end
    end
    remainder = rem;
  end

endmodule

// File: rtl/radix5_digit_emitter.sv
// Converts a 64-bit unsigned value to base-5 digits, least significant
// first, by repeated division by 5 (one division per accepted digit).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     value handshake, in_data is the 64-bit value
//   out_valid/out_ready   digit handshake
//   out_digit             base-5 digit 0..4
//   out_index             digit position, 0 = least significant
//   out_last              final digit of this value
//   out_ovf               with out_last: value was truncated by NUM_DIGITS
//   busy                  conversion in progress (~in_ready)
// Build option: define RADIX5_EMITTER_ZERO_SUPPRESS_EN to end each
// conversion at the most significant nonzero digit (at least one digit).
//
// state | meaning
// IDLE  | waiting for a value, in_ready=1
// RUN   | emitting digits of W, out_valid=1
module radix5_digit_emitter
  import radix5_emitter_pkg::*;
#(
  parameter int NUM_DIGITS = MAX_DIGITS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DIGIT_W-1:0] out_digit,
  output logic [IDX_W-1:0]   out_index,
  output logic               out_last,
  output logic               out_ovf,
  output logic               busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  w_q, w_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;

  logic [QUOT_W-1:0]  quot;
  logic [DIGIT_W-1:0] rem;
  logic               q_zero;
  logic               last_hit;
  logic               run;

  div_64_5 u_div (
    .x         (w_q),
    .quotient  (quot),
    .remainder (rem)
  );

  always_comb begin
    q_zero = (quot == '0);
`ifdef RADIX5_EMITTER_ZERO_SUPPRESS_EN
    last_hit = (cnt_q == LAST_IDX) || q_zero;
`else
    last_hit = (cnt_q == LAST_IDX);
`endif
    run = (state_q == RUN);

    // Outputs are gated by RUN so IDLE (and reset) shows all-zero digit
    // fields even when W still holds a leftover quotient.
    in_ready  = !run;
    busy      = run;
    out_valid = run;
    out_digit = run ? rem : '0;
    out_index = cnt_q;
    out_last  = run && last_hit;
    out_ovf   = run && last_hit && !q_zero;

    state_d = state_q;
    w_d     = w_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          w_d     = in_data;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (out_ready) begin
          w_d   = {2'b00, quot};
          cnt_d = cnt_q + 5'd1;
          if (last_hit) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      w_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_radix5_digit_emitter.sv
module tb_radix5_digit_emitter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_valid4;
  logic [63:0] in_data;
  logic        out_ready;

  logic        in_ready, out_valid, out_last, out_ovf, busy;
  logic [2:0]  out_digit;
  logic [4:0]  out_index;

  logic        in_ready4, out_valid4, out_last4, out_ovf4, busy4;
  logic [2:0]  out_digit4;
  logic [4:0]  out_index4;

  int errors = 0;
  int checks = 0;

  logic [2:0] dig [0:27];
  int         n_dig;
  int         last_idx;
  logic       ovf_seen;

  always #5 clk = ~clk;

  radix5_digit_emitter #(.NUM_DIGITS(28)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_digit(out_digit), .out_index(out_index), .out_last(out_last),
    .out_ovf(out_ovf), .busy(busy)
  );

  radix5_digit_emitter #(.NUM_DIGITS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_data(in_data), .out_valid(out_valid4), .out_ready(out_ready),
    .out_digit(out_digit4), .out_index(out_index4), .out_last(out_last4),
    .out_ovf(out_ovf4), .busy(busy4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Feeds one value to the 28-digit instance and checks every digit
  // against a division model; optionally stalls 3 cycles at stall_idx.
  task automatic convert(input logic [63:0] v, input int stall_idx, input string tag);
    logic [63:0] m, sum, pw;
    logic        exp_last;
    logic        done;
    @(negedge clk);
    chk({tag, "_accept_ready"}, 64'(in_ready), 64'd1);
    in_data   = v;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = ~v;
    m = v; sum = '0; pw = 64'd1; done = 1'b0; n_dig = 0; last_idx = -1; ovf_seen = 1'b0;
    for (int i = 0; i < 28 && !done; i++) begin
      @(negedge clk);
      exp_last = (i == 27);
`ifdef RADIX5_EMITTER_ZERO_SUPPRESS_EN
      exp_last = exp_last || ((m / 64'd5) == 64'd0);
`endif
      chk({tag, "_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_digit"}, 64'(out_digit), m % 64'd5);
      chk({tag, "_index"}, 64'(out_index), 64'(i));
      chk({tag, "_last"},  64'(out_last),  64'(exp_last));
      chk({tag, "_ovf"},   64'(out_ovf),   64'(exp_last && ((m / 64'd5) != 64'd0)));
      chk({tag, "_range"}, 64'(out_digit <= 3'd4), 64'd1);
      dig[i] = out_digit;
      sum    = sum + 64'(out_digit) * pw;
      pw     = pw * 64'd5;
      n_dig++;
      if (out_last) begin
        last_idx = i;
        ovf_seen = out_ovf;
      end
      if (i == stall_idx) begin
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'hDEAD_BEEF_0000_0001;
        repeat (3) begin
          @(negedge clk);
          chk({tag, "_stall_digit"}, 64'(out_digit), m % 64'd5);
          chk({tag, "_stall_index"}, 64'(out_index), 64'(i));
          chk({tag, "_stall_valid"}, 64'(out_valid), 64'd1);
          chk({tag, "_stall_ready"}, 64'(in_ready), 64'd0);
          chk({tag, "_stall_w"}, dut.w_q, m);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
      end
      m    = m / 64'd5;
      done = exp_last;
    end
    @(negedge clk);
    chk({tag, "_idle_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_idle_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_idle_busy"},  64'(busy), 64'd0);
    chk({tag, "_reassemble"}, sum, v);
  endtask

  logic [2:0] exp700 [0:3];
  int         exp_n;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_valid4 = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_digit",     64'(out_digit), 64'd0);
    chk("rst_index",     64'(out_index), 64'd0);
    chk("rst_last",      64'(out_last),  64'd0);
    chk("rst_ovf",       64'(out_ovf),   64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst4_last",     64'(out_last4), 64'd0);
    chk("rst4_valid",    64'(out_valid4), 64'd0);
    rst_n = 1'b1;

    // 123 = 3 + 4*5 + 4*25
    convert(64'd123, -1, "v123");
    chk("v123_d0", 64'(dig[0]), 64'd3);
    chk("v123_d1", 64'(dig[1]), 64'd4);
    chk("v123_d2", 64'(dig[2]), 64'd4);
`ifdef RADIX5_EMITTER_ZERO_SUPPRESS_EN
    chk("v123_last_idx", 64'(last_idx), 64'd2);
    exp_n = 1;
`else
    chk("v123_last_idx", 64'(last_idx), 64'd27);
    exp_n = 28;
`endif
    chk("v123_ovf", 64'(ovf_seen), 64'd0);

    convert(64'd0, -1, "v0");
    chk("v0_count", 64'(n_dig), 64'(exp_n));
    chk("v0_d0", 64'(dig[0]), 64'd0);

    convert(64'hFFFF_FFFF_FFFF_FFFF, -1, "vmax");
    chk("vmax_d0", 64'(dig[0]), 64'd0);
    chk("vmax_d27", 64'(dig[27]), 64'd2);
    chk("vmax_last_idx", 64'(last_idx), 64'd27);
    chk("vmax_ovf", 64'(ovf_seen), 64'd0);

    for (int r = 0; r < 200; r++) begin
      convert({$urandom, $urandom}, -1, "rand");
    end

    convert(64'd123, 1, "bp");

    // NUM_DIGITS=4, 700 = 0 + 0*5 + 3*25 + 0*125 + 1*625 -> truncated
    exp700[0] = 3'd0; exp700[1] = 3'd0; exp700[2] = 3'd3; exp700[3] = 3'd0;
    @(negedge clk);
    in_data = 64'd700; in_valid4 = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("n4_valid", 64'(out_valid4), 64'd1);
      chk("n4_digit", 64'(out_digit4), 64'(exp700[i]));
      chk("n4_index", 64'(out_index4), 64'(i));
      chk("n4_last",  64'(out_last4),  64'(i == 3));
      chk("n4_ovf",   64'(out_ovf4),   64'(i == 3));
    end
    @(negedge clk);
    chk("n4_idle", 64'(in_ready4), 64'd1);

    // Reset in the middle of a conversion at index 5
    @(negedge clk);
    in_data = 64'hFFFF_FFFF_FFFF_FFFF; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("mid_index", 64'(out_index), 64'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_valid", 64'(out_valid), 64'd0);
    chk("mrst_ready", 64'(in_ready),  64'd1);
    chk("mrst_busy",  64'(busy),      64'd0);
    chk("mrst_digit", 64'(out_digit), 64'd0);
    chk("mrst_index", 64'(out_index), 64'd0);
    chk("mrst_last",  64'(out_last),  64'd0);
    chk("mrst_ovf",   64'(out_ovf),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    convert(64'd123, -1, "after_rst");
    chk("after_rst_d0", 64'(dig[0]), 64'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
